// File: rtl/keypad_scan_decoder.sv
// Matrix keypad scanner: column drive, row synchroniser, frame debounce,
// multi-key rejection and optional auto-repeat.
module keypad_scan_decoder #(
    parameter int ROWS                = 4,
    parameter int COLS                = 4,
    parameter int SCAN_CYCLES         = 8,
    parameter int DEBOUNCE_FRAMES     = 3,
    parameter int REPEAT_EN           = 0,
    parameter int REPEAT_DELAY_FRAMES = 8,
    parameter int REPEAT_RATE_FRAMES  = 4,
    localparam int CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   filas,
    output logic [COLS-1:0]   columnas,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_held,
    output logic              key_multi
);

    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SLOT_W  = $clog2(SCAN_CYCLES);
    localparam int CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                             REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    logic [ROWS-1:0]   sync1, sync2;
    logic [SLOT_W-1:0] slot_q;
    logic [COL_W-1:0]  col_q;
    logic [1:0]        acc_cnt;
    logic [CODE_W-1:0] acc_idx;

    logic              slot_last, col_last, frame_end;
    logic [1:0]        row_cnt;
    logic [CODE_W-1:0] row_idx;
    logic [2:0]        sum;
    logic [1:0]        tot;
    logic [CODE_W-1:0] tot_idx;

    state_t            state, state_n;
    logic [CODE_W-1:0] cand, cand_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [RPT_W-1:0]  rpt, rpt_n;
    logic              first, first_n;
    logic              valid_n, multi_n;
    logic [CODE_W-1:0] code_n;
    logic              single_cand;
    logic [RPT_W-1:0]  rpt_lim;

    assign slot_last = (slot_q == SLOT_W'(SCAN_CYCLES - 1));
    assign col_last  = (col_q == COL_W'(COLS - 1));
    assign frame_end = slot_last && col_last;

    always_comb begin
        columnas        = '0;
        columnas[col_q] = 1'b1;
    end

    // Pressed rows in the current column, merged into the frame tally
    always_comb begin
        row_cnt = 2'd0;
        row_idx = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (sync2[r]) begin
                if (row_cnt != 2'd2)
                    row_cnt = row_cnt + 2'd1;
                row_idx = CODE_W'(int'(col_q) * ROWS + r);
            end
        end
        sum     = {1'b0, acc_cnt} + {1'b0, row_cnt};
        tot     = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        tot_idx = (row_cnt == 2'd1) ? row_idx : acc_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            slot_q  <= '0;
            col_q   <= '0;
            acc_cnt <= 2'd0;
            acc_idx <= '0;
        end else begin
            sync1 <= filas;
            sync2 <= sync1;
            if (slot_last) begin
                slot_q  <= '0;
                col_q   <= col_last ? '0 : col_q + 1'b1;
                acc_cnt <= col_last ? 2'd0 : tot;
                acc_idx <= col_last ? '0 : tot_idx;
            end else begin
                slot_q <= slot_q + 1'b1;
            end
        end
    end

    assign single_cand = (tot == 2'd1) && (tot_idx == cand);
    assign rpt_lim     = first ? RPT_W'(REPEAT_DELAY_FRAMES - 1)
                               : RPT_W'(REPEAT_RATE_FRAMES - 1);

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        rpt_n   = rpt;
        first_n = first;
        valid_n = 1'b0;
        code_n  = key_code;
        multi_n = key_multi;
        if (frame_end) begin
            multi_n = (tot == 2'd2);
            unique case (state)
                IDLE: begin
                    if (tot == 2'd1) begin
                        cand_n = tot_idx;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_n = HELD;
                            valid_n = 1'b1;
                            code_n  = tot_idx;
                            rpt_n   = '0;
                            first_n = 1'b1;
                            cnt_n   = '0;
                        end else begin
                            state_n = DEB_PRESS;
                            cnt_n   = CNT_W'(1);
                        end
                    end
                end
                DEB_PRESS: begin
                    if (!single_cand) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt >= CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                        state_n = HELD;
                        valid_n = 1'b1;
                        code_n  = cand;
                        rpt_n   = '0;
                        first_n = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (single_cand) begin
                        // rpt stays 0 when repeat is disabled
                        if (REPEAT_EN != 0) begin
                            if (rpt >= rpt_lim) begin
                                valid_n = 1'b1;
                                code_n  = cand;
                                rpt_n   = '0;
                                first_n = 1'b0;
                            end else begin
                                rpt_n = rpt + 1'b1;
                            end
                        end
                    end else if (DEBOUNCE_FRAMES == 1) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DEB_RELEASE;
                        cnt_n   = CNT_W'(1);
                    end
                end
                DEB_RELEASE: begin
                    if (single_cand) begin
                        state_n = HELD;
                        cnt_n   = '0;
                    end else if (cnt >= CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            rpt       <= '0;
            first     <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_multi <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            rpt       <= rpt_n;
            first     <= first_n;
            key_valid <= valid_n;
            key_code  <= code_n;
            key_multi <= multi_n;
        end
    end

    assign key_held = (state == HELD) || (state == DEB_RELEASE);

endmodule

// File: doc/keypad_scan_decoder.md
# keypad_scan_decoder

Parametrised matrix-keypad scanner and decoder for the PilOut dosing front panel. It drives one keypad column at a time and samples the row lines through a synchroniser. It debounces on whole scan frames and emits a one-cycle `key_valid` strobe with a binary key index per accepted press. Over the previous comparator it adds active column drive, reset, multi-key rejection, release debouncing and optional auto-repeat; downstream logic maps `key_code` to digits/commands.

## Interface
- `ROWS`, 4, number of row inputs (≥1)
- `COLS`, 4, number of driven columns (≥1)
- `SCAN_CYCLES`, 8, clocks each column is driven (≥4)
- `DEBOUNCE_FRAMES`, 3, consecutive identical frames to accept press or release (≥1)
- `REPEAT_EN`, 0, 1 enables auto-repeat while held
- `REPEAT_DELAY_FRAMES`, 8, frames from first strobe to first repeat (≥1)
- `REPEAT_RATE_FRAMES`, 4, frames between subsequent repeats (≥1)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `filas`  in  ROWS  asynchronous row sense, 1 = pressed contact on driven column
- `columnas`  out  COLS  one-hot column drive, active high
- `key_valid`  out  1  one-cycle strobe: new press or repeat
- `key_code`  out  CODE_W = max(1, clog2(ROWS*COLS))  key index = col*ROWS + row (bit 0 = index 0)
- `key_held`  out  1  level: accepted key currently held
- `key_multi`  out  1  level: last completed frame saw ≥2 pressed keys

## Operation
- Scan: `filas` passes a 2-flop synchroniser. Column c is driven for SCAN_CYCLES clocks, then c+1, wrapping COLS-1→0. Rows are sampled on the last clock of each column slot.
- Frame: COLS column slots. It accumulates pressed-key count (saturating at 2) and the index of the pressed key (any, when count = 1). Evaluation happens at the frame-end sample. Frame classes: NONE, SINGLE(k), MULTI.
- `key_multi` updates at every frame end to (class == MULTI).
- FSM, state `cand` register:
  - IDLE: SINGLE(k) → DEB_PRESS, cand=k, cnt=1. With DEBOUNCE_FRAMES=1, go directly to HELD with strobe. Otherwise stay.
  - DEB_PRESS: SINGLE(cand) → cnt+1. At cnt==DEBOUNCE_FRAMES → HELD, strobe, `key_code`=cand, rpt=0. Anything else → IDLE.
  - HELD: SINGLE(cand) → stay, rpt+1 if REPEAT_EN. Anything else (NONE, MULTI, other key) → DEB_RELEASE, cnt=1.
  - DEB_RELEASE: SINGLE(cand) → HELD, no strobe, rpt unchanged. Otherwise cnt+1. At cnt==DEBOUNCE_FRAMES → IDLE.
- Repeat: in HELD, when rpt reaches REPEAT_DELAY_FRAMES (first) or REPEAT_RATE_FRAMES (later), strobe with the same `key_code` and set rpt=0.
- `key_held` = state ∈ {HELD, DEB_RELEASE}.
- A second key pressed while one is held never strobes. After release debounce, a remaining single key is debounced from IDLE as a fresh press.
- All counters saturate and never wrap.

## Timing
- Reset values: `columnas`=one-hot bit 0, scan counters 0, synchroniser 0, FSM IDLE, cand/cnt/rpt 0, `key_valid`=0, `key_code`=0, `key_held`=0, `key_multi`=0.
- Reset mid-operation discards all state. A key still held after reset is re-debounced and strobes again.
- Frame period = COLS*SCAN_CYCLES clocks. Input-to-sample latency is 2 clocks plus the slot position.
- `key_valid`, `key_code`, `key_held` and `key_multi` are registered. They change on the clock after the frame-end sample.
- `key_valid` is high exactly 1 clock. `key_code` is stable from a strobe until the next strobe.
- Repeat is ignored when REPEAT_EN=0 (rpt held 0).

## Test plan
Defaults (ROWS=COLS=4, SCAN_CYCLES=8, DEBOUNCE_FRAMES=3); frame = 32 clocks.
- Single press, row 2 on column 1, stable 10 frames → exactly one strobe with `key_code`=6 at the end of frame 3; `key_held`=1 through frame 10.
- Bounce: row toggles every 20 clocks for 4 frames, then stable → no strobe during bounce; one strobe 3 clean frames later.
- REPEAT_EN=1, DELAY=8, RATE=4, key 0 held 20 frames → strobes at frames 3, 11, 15, 19, all `key_code`=0.
- Keys 0 and 15 pressed together → `key_multi`=1, no strobe. Release key 15 → `key_multi`=0 and one strobe `key_code`=0 after 3 frames.
- Held key 5 drops for 1 frame then returns → no strobe, `key_held` stays 1. Released 3 frames → `key_held`=0 after frame 3.
- `rst` pulsed 1 clock while key 9 held → next cycle all outputs 0 and `columnas`=0001; strobe `key_code`=9 again after 3 frames.
